// File: rtl/div_seq.sv
// Sequential radix-2 restoring divider for the EX stage: 32-bit quotient and remainder in 33 cycles.
// Optional macro DIV_SIGNED_EN enables signed division selected by signed_div_i; otherwise every division is unsigned.
module div_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stallreq_o
);

    typedef enum logic [1:0] {
        S_FREE    = 2'b00,
        S_DIVZERO = 2'b01,
        S_ON      = 2'b10,
        S_END     = 2'b11
    } state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [64:0] r_part;
    logic [31:0] r_divisor;
    logic [63:0] r_result;
    logic        r_ready;

    logic [31:0] w_abs_dividend;
    logic [31:0] w_abs_divisor;
    logic [33:0] w_trial;
    logic [64:0] w_part_next;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic        w_unused;

    // Trial subtraction on the upper 33 bits; a borrow means the quotient bit is 0.
    // A non-borrowing difference is always below the divisor, so w_trial[32] is zero there.
    assign w_trial     = {1'b0, r_part[64:32]} - {2'b00, r_divisor};
    assign w_part_next = w_trial[33] ? {r_part[63:0], 1'b0}
                                     : {w_trial[31:0], r_part[31:0], 1'b1};

`ifdef DIV_SIGNED_EN
    logic r_neg_quot;
    logic r_neg_rem;
    logic w_neg_a;
    logic w_neg_b;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    assign w_neg_a        = signed_div_i & opdata1_i[31];
    assign w_neg_b        = signed_div_i & opdata2_i[31];
    // -2^31 maps to 32'h80000000, which is correct when read as unsigned.
    assign w_abs_dividend = w_neg_a ? neg32(opdata1_i) : opdata1_i;
    assign w_abs_divisor  = w_neg_b ? neg32(opdata2_i) : opdata2_i;
    assign w_quot         = r_neg_quot ? neg32(w_part_next[31:0])  : w_part_next[31:0];
    assign w_rem          = r_neg_rem  ? neg32(w_part_next[64:33]) : w_part_next[64:33];
    assign w_unused       = w_trial[32];

    // Sign-correction flags, captured together with the operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neg_quot <= 1'b0;
            r_neg_rem  <= 1'b0;
        end else if (!annul_i && (r_state == S_FREE) && start_i) begin
            r_neg_quot <= w_neg_a ^ w_neg_b;
            r_neg_rem  <= w_neg_a;
        end else begin
            r_neg_quot <= r_neg_quot;
            r_neg_rem  <= r_neg_rem;
        end
    end
`else
    assign w_abs_dividend = opdata1_i;
    assign w_abs_divisor  = opdata2_i;
    assign w_quot         = w_part_next[31:0];
    assign w_rem          = w_part_next[64:33];
    assign w_unused       = w_trial[32] ^ signed_div_i;
`endif

    // Control FSM with datapath and registered result/ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FREE;
            r_cnt     <= 6'd0;
            r_part    <= 65'd0;
            r_divisor <= 32'd0;
            r_result  <= 64'd0;
            r_ready   <= 1'b0;
        end else if (annul_i) begin
            r_state  <= S_FREE;
            r_result <= 64'd0;
            r_ready  <= 1'b0;
        end else begin
            case (r_state)
                S_FREE: begin
                    r_result <= 64'd0;
                    r_ready  <= 1'b0;
                    if (start_i) begin
                        r_cnt     <= 6'd0;
                        r_part    <= {32'd0, w_abs_dividend, 1'b0};
                        r_divisor <= w_abs_divisor;
                        r_state   <= (opdata2_i == 32'd0) ? S_DIVZERO : S_ON;
                    end else begin
                        r_state <= S_FREE;
                    end
                end
                S_DIVZERO: begin
                    r_state  <= S_END;
                    r_result <= 64'd0;
                    r_ready  <= 1'b1;
                end
                S_ON: begin
                    r_part <= w_part_next;
                    r_cnt  <= r_cnt + 6'd1;
                    if (r_cnt == 6'd31) begin
                        r_state  <= S_END;
                        r_result <= {w_rem, w_quot};
                        r_ready  <= 1'b1;
                    end else begin
                        r_state  <= S_ON;
                        r_result <= 64'd0;
                        r_ready  <= 1'b0;
                    end
                end
                S_END: begin
                    if (!start_i) begin
                        r_state  <= S_FREE;
                        r_result <= 64'd0;
                        r_ready  <= 1'b0;
                    end else begin
                        r_state  <= S_END;
                        r_result <= r_result;
                        r_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_FREE;
                    r_result <= 64'd0;
                    r_ready  <= 1'b0;
                end
            endcase
        end
    end

    assign result_o   = r_result;
    assign ready_o    = r_ready;
    assign stallreq_o = start_i & ~r_ready;

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq; expectations follow DIV_SIGNED_EN when it is defined.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int n_checks = 0;
    int n_errors = 0;

`ifdef DIV_SIGNED_EN
    localparam logic [63:0] EXP_NEG7_2     = 64'hFFFFFFFF_FFFFFFFD;
    localparam logic [63:0] EXP_7_NEG2     = 64'h00000001_FFFFFFFD;
    localparam logic [63:0] EXP_NEG100_NEG7 = 64'hFFFFFFFE_0000000E;
    localparam logic [63:0] EXP_MIN_NEG1   = 64'h00000000_80000000;
`else
    localparam logic [63:0] EXP_NEG7_2     = 64'h00000001_7FFFFFFC;
    localparam logic [63:0] EXP_7_NEG2     = 64'h00000007_00000000;
    localparam logic [63:0] EXP_NEG100_NEG7 = 64'hFFFFFF9C_00000000;
    localparam logic [63:0] EXP_MIN_NEG1   = 64'h80000000_00000000;
`endif

    always #5 clk = ~clk;

    div_seq u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (ready_o !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat);
        int lat;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        #1;
        check_val({tag, "_stall"}, {63'd0, stallreq_o}, 64'd1);
        tick();
        check_val({tag, "_busy"}, {63'd0, ready_o}, 64'd0);
        wait_ready(lat);
        check_val({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check_val({tag, "_res"}, result_o, exp_res);
        check_val({tag, "_nostall"}, {63'd0, stallreq_o}, 64'd0);
        opdata1_i = ~a;
        opdata2_i = ~b;
        tick();
        check_val({tag, "_hold_rdy"}, {63'd0, ready_o}, 64'd1);
        check_val({tag, "_hold_res"}, result_o, exp_res);
        start_i = 1'b0;
        tick();
        check_val({tag, "_free_rdy"}, {63'd0, ready_o}, 64'd0);
        check_val({tag, "_free_res"}, result_o, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst_n        = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        #12;
        check_val("rst_res", result_o, 64'd0);
        check_val("rst_rdy", {63'd0, ready_o}, 64'd0);
        check_val("rst_stall", {63'd0, stallreq_o}, 64'd1);
        start_i = 1'b0;
        #11;
        rst_n = 1'b1;
        tick();

        run_div("u100_7",   1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 32);
        run_div("u7_100",   1'b0, 32'd7,          32'd100,        64'h00000007_00000000, 32);
        run_div("uffff_3",  1'b0, 32'hFFFFFFFF,   32'd3,          64'h00000000_55555555, 32);
        run_div("ubig",     1'b0, 32'hFFFFFFFF,   32'h80000001,   64'h7FFFFFFE_00000001, 32);
        run_div("s_n7_2",   1'b1, 32'hFFFFFFF9,   32'd2,          EXP_NEG7_2,            32);
        run_div("s_7_n2",   1'b1, 32'd7,          32'hFFFFFFFE,   EXP_7_NEG2,            32);
        run_div("s_n100_n7",1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   EXP_NEG100_NEG7,       32);
        run_div("div0",     1'b0, 32'd5,          32'd0,          64'd0,                 1);
        run_div("sdiv0",    1'b1, 32'hFFFFFFF9,   32'd0,          64'd0,                 1);

        // start toggled while iterating: no effect on result or latency
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd33;
        start_i      = 1'b1;
        tick();
        for (int i = 1; i <= 31; i++) begin
            start_i   = (i % 2 == 0);
            opdata1_i = 32'(i);
            #1;
            check_val("tog_stall", {63'd0, stallreq_o}, {63'd0, start_i});
            tick();
            check_val("tog_busy", {63'd0, ready_o}, 64'd0);
        end
        start_i = 1'b1;
        #1;
        check_val("tog_stall_last", {63'd0, stallreq_o}, 64'd1);
        tick();
        check_val("tog_rdy", {63'd0, ready_o}, 64'd1);
        check_val("tog_res", result_o, 64'h0000000A_0000001E);
        start_i = 1'b0;
        tick();

        // annul at iteration 10, then 9/3 on the following cycle
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val("ann_busy", {63'd0, ready_o}, 64'd0);
        end
        annul_i = 1'b1;
        tick();
        check_val("ann_rdy", {63'd0, ready_o}, 64'd0);
        check_val("ann_res", result_o, 64'd0);
        annul_i   = 1'b0;
        opdata1_i = 32'd9;
        opdata2_i = 32'd3;
        tick();
        wait_ready(lat);
        check_val("ann_new_lat", 64'(lat), 64'd32);
        check_val("ann_new_res", result_o, 64'h00000000_00000003);

        // asynchronous reset while in END clears outputs without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_res", result_o, 64'd0);
        check_val("arst_rdy", {63'd0, ready_o}, 64'd0);
        start_i = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // annul on the completing edge beats completion
        opdata1_i = 32'd9;
        opdata2_i = 32'd3;
        start_i   = 1'b1;
        tick();
        for (int i = 0; i < 31; i++) tick();
        annul_i = 1'b1;
        tick();
        check_val("annend_rdy", {63'd0, ready_o}, 64'd0);
        check_val("annend_res", result_o, 64'd0);
        annul_i = 1'b0;
        start_i = 1'b0;
        tick();
        check_val("annend_idle", {63'd0, ready_o}, 64'd0);

        // reset at iteration 20, then a fresh signed -2^31 / -1
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mrst_res", result_o, 64'd0);
        check_val("mrst_rdy", {63'd0, ready_o}, 64'd0);
        start_i = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check_val("mrst_idle", {63'd0, ready_o}, 64'd0);
        run_div("s_min_n1", 1'b1, 32'h80000000, 32'hFFFFFFFF, EXP_MIN_NEG1, 32);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL provide clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL provide signed_div_i  input  1  1 = signed division, 0 = unsigned.
REQ-004 SHALL provide opdata1_i  input  32  dividend.
REQ-005 SHALL provide opdata2_i  input  32  divisor.
REQ-006 SHALL provide start_i  input  1  request from EX stage; held high until ready_o is seen.
REQ-007 SHALL provide annul_i  input  1  cancel the current operation (flush or exception).
REQ-008 SHALL provide result_o  output  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}.
REQ-009 SHALL provide ready_o  output  1  result_o valid.
REQ-010 SHALL provide stallreq_o  output  1  EX stall request while a division is in flight.

Function
REQ-011 SHALL implement FSM states FREE, DIVZERO, ON, END, encoded in 2 bits.
REQ-012 In FREE with start_i=1 and annul_i=0: SHALL latch operands, clear the 6-bit iteration counter, and go to DIVZERO if opdata2_i==0, else to ON.
REQ-013 In ON: SHALL perform one radix-2 restoring step per cycle (65-bit partial register; trial subtract of the divisor from the upper 33 bits; quotient bit shifted in).
REQ-014 In ON: SHALL go to END on the edge that completes iteration 32 (counter==31), so END holds after 33 edges counted from the start-sampling edge.
REQ-015 In DIVZERO: SHALL go to END on the next edge with result = 64'h0.
REQ-016 In END: SHALL hold ready_o=1 and result_o stable while start_i=1, then return to FREE on the first edge with start_i=0.
REQ-017 ready_o and result_o SHALL be registered, and SHALL be 0 in every state except END.
REQ-018 stallreq_o SHALL be 1 when start_i=1 and ready_o=0; otherwise 0.
REQ-019 start_i SHALL be ignored in ON, DIVZERO and END; operands are sampled only in FREE.
REQ-020 annul_i=1 in any state SHALL force FREE on the next edge with ready_o=0 and result_o=0, and SHALL take priority over start_i and completion.
REQ-021 Signed mode: SHALL divide absolute values; quotient negated iff operand signs differ; remainder takes the sign of the dividend.
REQ-022 Signed mode: -2^31 / -1 SHALL yield quotient 32'h80000000 (wrap) and remainder 0; the absolute value of -2^31 SHALL be 32'h80000000 interpreted unsigned.

Reset
REQ-023 rst_n=0 SHALL immediately force FREE, counter 0, latched operands 0, result_o=0 and ready_o=0, independent of clk.
REQ-024 Reset mid-operation SHALL discard the operation; after release the first start_i SHALL be handled as in REQ-012.

Configuration
REQ-025 With DIV_SIGNED_EN defined: signed_div_i SHALL select signed or unsigned operation per REQ-021 and REQ-022.
REQ-026 Without DIV_SIGNED_EN: signed_div_i SHALL be ignored, all divisions SHALL be unsigned, and the sign-correction logic SHALL be absent; latency is unchanged.

Verification
REQ-027 Unsigned 100/7, start held: ready_o rises 33 edges after start is sampled; result_o = {32'd2, 32'd14}; start dropped -> FREE next edge.
REQ-028 Signed -7/2 (32'hFFFFFFF9 / 2, macro on): result_o = {32'hFFFFFFFF, 32'hFFFFFFFD}; same input with the macro off: {32'd1, 32'h7FFFFFFC}.
REQ-029 5/0: DIVZERO then END; ready_o high 2 edges after start is sampled; result_o = 64'h0.
REQ-030 100/7 with annul_i pulsed at iteration 10: FREE next edge, ready_o never rises; new start 9/3 on the following cycle -> {32'd0, 32'd3}.
REQ-031 rst_n low at iteration 20: outputs 0 immediately; after release, 32'h80000000 / 32'hFFFFFFFF signed -> {32'd0, 32'h80000000}.
REQ-032 start_i toggled in ON: no effect on result or latency; stallreq_o tracks REQ-018 every cycle.
